// File: rtl/multi_lane_bdu_pkg.sv
// rtl/multi_lane_bdu_pkg.sv - shared state encoding and width helpers for multi_lane_bdu
package multi_lane_bdu_pkg;

    typedef logic [1:0] bdu_state_t;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACTIVE = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

    // Partial-distance width: one coordinate magnitude, summed over d dims, plus headroom
    function automatic int pw_calc(input int b, input int d);
        return b + $clog2(d) + 1;
    endfunction

    // Index width that never collapses to zero bits for a single-entry range
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bdu_lane.sv
// rtl/bdu_lane.sv - one reference lane: per-dim prefix diffs, L1 lower bound, threshold freeze
module bdu_lane
    import multi_lane_bdu_pkg::*;
#(
    parameter int B = 32,
    parameter int D = 3,
    localparam int PW = pw_calc(B, D),
    localparam int DW = idx_w(D)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr_i,
    input  logic          beat_i,
    input  logic [DW-1:0] dim_i,
    input  logic          q_bit_i,
    input  logic          r_bit_i,
    input  logic [PW-1:0] thr_i,
    output logic [PW-1:0] pd_o,
    output logic          term_o,
    output logic          term_next_o
);

    localparam int KW = $clog2(B + 1);
    localparam logic [KW:0] B_W = (KW + 1)'(B);

    logic signed [B:0] diff_q [D];
    logic signed [B:0] diff_d [D];
    logic [KW-1:0]     k_q    [D];
    logic [KW-1:0]     k_d    [D];
    logic [PW-1:0]     pd_q, pd_d;
    logic              term_q, term_d;
    logic signed [B:0] delta;
    logic [B:0]        mag;
    logic [KW:0]       sh;

    assign pd_o        = pd_q;
    assign term_o      = term_q;
    assign term_next_o = term_d;

    // Signed contribution of this beat's bit pair: q-r in {-1,0,+1}
    always_comb begin
        case ({q_bit_i, r_bit_i})
            2'b10:   delta = {{B{1'b0}}, 1'b1};
            2'b01:   delta = '1;
            default: delta = '0;
        endcase
    end

    // Advance the addressed dim unless frozen, then rebuild the bound from next-state values
    always_comb begin
        pd_d = '0;
        mag  = '0;
        sh   = '0;
        for (int d = 0; d < D; d++) begin
            diff_d[d] = diff_q[d];
            k_d[d]    = k_q[d];
            if (beat_i && !term_q && (dim_i == DW'(d))) begin
                diff_d[d] = (diff_q[d] <<< 1) + delta;
                k_d[d]    = k_q[d] + KW'(1);
            end
            mag = diff_d[d][B] ? -diff_d[d] : diff_d[d];
            sh  = B_W - {1'b0, k_d[d]};
            if (mag != '0) begin
                pd_d = pd_d + ((PW'(mag) - PW'(1)) << sh) + PW'(1);
            end
        end
        term_d = term_q | (pd_d > thr_i);
    end

    // Lane registers: cleared by reset or query start, otherwise take next state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int d = 0; d < D; d++) begin
                diff_q[d] <= '0;
                k_q[d]    <= '0;
            end
            pd_q   <= '0;
            term_q <= 1'b0;
        end else if (clr_i) begin
            for (int d = 0; d < D; d++) begin
                diff_q[d] <= '0;
                k_q[d]    <= '0;
            end
            pd_q   <= '0;
            term_q <= 1'b0;
        end else begin
            diff_q <= diff_d;
            k_q    <= k_d;
            pd_q   <= pd_d;
            term_q <= term_d;
        end
    end

endmodule

// File: rtl/multi_lane_bdu.sv
// rtl/multi_lane_bdu.sv - bit-serial multi-lane L1 bound unit with early termination
module multi_lane_bdu
    import multi_lane_bdu_pkg::*;
#(
    parameter int B = 32,
    parameter int D = 3,
    parameter int LANES = 4,
    localparam int PW = pw_calc(B, D),
    localparam int DW = idx_w(D)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [PW-1:0]       threshold,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DW-1:0]       dim,
    input  logic                q_bit,
    input  logic [LANES-1:0]    r_bits,
    output logic [LANES-1:0]    terminate,
    output logic                done,
    output logic                seq_err,
    output logic [LANES*PW-1:0] partial_dist
);

    localparam int NBEATS = D * B;
    localparam int CW = $clog2(NBEATS + 1);
    localparam logic [CW-1:0] LAST_BEAT = CW'(NBEATS - 1);
    localparam logic [DW-1:0] LAST_DIM  = DW'(D - 1);

    bdu_state_t       state_q, state_d;
    logic [CW-1:0]    beat_cnt_q, beat_cnt_d;
    logic [DW-1:0]    exp_dim_q, exp_dim_d;
    logic             seq_err_q, seq_err_d;
    logic [PW-1:0]    thr_q, thr_d;
    logic             accept;
    logic             beat_ok;
    logic [LANES-1:0] term_next;

    // A beat that coincides with start belongs to no query and is dropped
    assign in_ready = (state_q == ST_ACTIVE);
    assign accept   = in_valid && in_ready && !start;
    assign beat_ok  = accept && (dim == exp_dim_q);
    assign done     = (state_q == ST_DONE);
    assign seq_err  = seq_err_q;

    // Sequencing: expected dim, beat count, sticky order error, end-of-query detection
    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        exp_dim_d  = exp_dim_q;
        seq_err_d  = seq_err_q;
        thr_d      = thr_q;
        if (start) begin
            state_d    = ST_ACTIVE;
            beat_cnt_d = '0;
            exp_dim_d  = '0;
            seq_err_d  = 1'b0;
            thr_d      = threshold;
        end else if (state_q == ST_ACTIVE) begin
            if (accept && !beat_ok) begin
                seq_err_d = 1'b1;
            end
            if (beat_ok) begin
                beat_cnt_d = beat_cnt_q + CW'(1);
                exp_dim_d  = (exp_dim_q == LAST_DIM) ? '0 : exp_dim_q + DW'(1);
            end
            if ((beat_ok && (beat_cnt_q == LAST_BEAT)) || (&term_next)) begin
                state_d = ST_DONE;
            end
        end
    end

    // Controller registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            beat_cnt_q <= '0;
            exp_dim_q  <= '0;
            seq_err_q  <= 1'b0;
            thr_q      <= '0;
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
            exp_dim_q  <= exp_dim_d;
            seq_err_q  <= seq_err_d;
            thr_q      <= thr_d;
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        bdu_lane #(
            .B(B),
            .D(D)
        ) u_lane (
            .clk         (clk),
            .rst         (rst),
            .clr_i       (start),
            .beat_i      (beat_ok),
            .dim_i       (dim),
            .q_bit_i     (q_bit),
            .r_bit_i     (r_bits[l]),
            .thr_i       (thr_q),
            .pd_o        (partial_dist[l*PW +: PW]),
            .term_o      (terminate[l]),
            .term_next_o (term_next[l])
        );
    end

endmodule

// File: tb/tb_multi_lane_bdu.sv
// tb/tb_multi_lane_bdu.sv - scoreboard bench for multi_lane_bdu
`timescale 1ns/1ps
module tb_multi_lane_bdu;

    localparam int B      = 32;
    localparam int D      = 3;
    localparam int LANES  = 4;
    localparam int PW     = B + $clog2(D) + 1;
    localparam int DW     = $clog2(D);
    localparam int NBEATS = D * B;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic                start = 1'b0;
    logic [PW-1:0]       threshold = '0;
    logic                in_valid = 1'b0;
    logic                in_ready;
    logic [DW-1:0]       dim = '0;
    logic                q_bit = 1'b0;
    logic [LANES-1:0]    r_bits = '0;
    logic [LANES-1:0]    terminate;
    logic                done;
    logic                seq_err;
    logic [LANES*PW-1:0] partial_dist;

    typedef struct {
        logic [LANES*PW-1:0] pd;
        logic [LANES-1:0]    term;
        logic                done;
    } exp_t;

    exp_t   sb[$];
    int     n_vec = 0;
    int     n_err = 0;
    logic [B-1:0] q_v [D];
    logic [B-1:0] r_v [LANES][D];
    longint thr_v;
    longint m_pd [LANES];
    bit     m_term [LANES];
    bit     m_done;
    int     beats_done;
    int     first_term0;

    always #5 clk = ~clk;

    multi_lane_bdu #(.B(B), .D(D), .LANES(LANES)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .threshold    (threshold),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .dim          (dim),
        .q_bit        (q_bit),
        .r_bits       (r_bits),
        .terminate    (terminate),
        .done         (done),
        .seq_err      (seq_err),
        .partial_dist (partial_dist)
    );

    function automatic logic [PW-1:0] pd_lane(input int l);
        return partial_dist[l*PW +: PW];
    endfunction

    // Smallest |q-r| consistent with the k leading bits seen so far
    function automatic longint lb(input logic [B-1:0] qv, input logic [B-1:0] rv, input int k);
        longint pq, pr, df;
        if (k == 0) return 0;
        pq = longint'(qv >> (B - k));
        pr = longint'(rv >> (B - k));
        df = (pq > pr) ? pq - pr : pr - pq;
        if (df == 0) return 0;
        return ((df - 1) << (B - k)) + 1;
    endfunction

    task automatic set_all(input logic [B-1:0] q, input logic [B-1:0] r0, input logic [B-1:0] r1,
                           input logic [B-1:0] r2, input logic [B-1:0] r3);
        for (int d = 0; d < D; d++) begin
            q_v[d]    = q;
            r_v[0][d] = r0;
            r_v[1][d] = r1;
            r_v[2][d] = r2;
            r_v[3][d] = r3;
        end
    endtask

    task automatic do_start(input longint thr);
        @(negedge clk);
        start     = 1'b1;
        threshold = PW'(thr);
        thr_v     = thr;
        @(negedge clk);
        start = 1'b0;
        for (int l = 0; l < LANES; l++) begin
            m_pd[l]   = 0;
            m_term[l] = 1'b0;
        end
        m_done      = 1'b0;
        beats_done  = 0;
        first_term0 = -1;
        sb.delete();
        n_vec++;
        if (in_ready !== 1'b1 || done !== 1'b0 || seq_err !== 1'b0 || terminate !== '0 || partial_dist !== '0) begin
            n_err++;
            $display("FAIL start_clear ready=%b done=%b seq_err=%b term=%b pd=%h want 1/0/0/0/0",
                     in_ready, done, seq_err, terminate, partial_dist);
        end
    endtask

    task automatic run_query(input int max_beats);
        exp_t   e;
        longint s;
        int     p, d;
        for (int i = 0; i < max_beats && !m_done; i++) begin
            p = i / D;
            d = i % D;
            in_valid = 1'b1;
            dim      = DW'(d);
            q_bit    = q_v[d][B-1-p];
            for (int l = 0; l < LANES; l++) r_bits[l] = r_v[l][d][B-1-p];
            for (int l = 0; l < LANES; l++) begin
                if (!m_term[l]) begin
                    s = 0;
                    for (int dd = 0; dd < D; dd++) s += lb(q_v[dd], r_v[l][dd], (dd <= d) ? p + 1 : p);
                    m_pd[l] = s;
                    if (s > thr_v) m_term[l] = 1'b1;
                end
            end
            m_done = (i == NBEATS - 1);
            if (m_term[0] && m_term[1] && m_term[2] && m_term[3]) m_done = 1'b1;
            for (int l = 0; l < LANES; l++) begin
                e.pd[l*PW +: PW] = m_pd[l][PW-1:0];
                e.term[l]        = m_term[l];
            end
            e.done = m_done;
            sb.push_back(e);
            @(negedge clk);
            e = sb.pop_front();
            n_vec++;
            if (partial_dist !== e.pd) begin
                n_err++;
                $display("FAIL beat%0d_pd got=%h want=%h", i, partial_dist, e.pd);
            end
            n_vec++;
            if (terminate !== e.term) begin
                n_err++;
                $display("FAIL beat%0d_term got=%b want=%b", i, terminate, e.term);
            end
            n_vec++;
            if (done !== e.done) begin
                n_err++;
                $display("FAIL beat%0d_done got=%b want=%b", i, done, e.done);
            end
            if (terminate[0] === 1'b1 && first_term0 < 0) first_term0 = i;
            beats_done = i + 1;
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        #3;
        n_vec++;
        if (in_ready !== 1'b0 || done !== 1'b0 || seq_err !== 1'b0 || terminate !== '0 || partial_dist !== '0) begin
            n_err++;
            $display("FAIL reset_state ready=%b done=%b seq_err=%b term=%b pd=%h want all 0",
                     in_ready, done, seq_err, terminate, partial_dist);
        end
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b1;
        dim      = '0;
        q_bit    = 1'b1;
        r_bits   = '0;
        @(negedge clk);
        in_valid = 1'b0;
        n_vec++;
        if (in_ready !== 1'b0 || done !== 1'b0 || partial_dist !== '0) begin
            n_err++;
            $display("FAIL idle_ignore ready=%b done=%b pd=%h want 0/0/0", in_ready, done, partial_dist);
        end
    endtask

    task automatic test_exact;
        set_all(32'h0000FFFF, 32'h0000FF00, 32'h0000FFFF, 32'h0000FFFF, 32'h0000FFFF);
        do_start(64'hFFFF);
        run_query(NBEATS);
        n_vec++;
        if (pd_lane(0) !== PW'(765) || terminate[0] !== 1'b0 || done !== 1'b1 || beats_done != 96) begin
            n_err++;
            $display("FAIL exact_final pd0=%0d term0=%b done=%b beats=%0d want 765/0/1/96",
                     pd_lane(0), terminate[0], done, beats_done);
        end
    endtask

    task automatic test_terminate;
        set_all(32'h0000FFFF, 32'h0000FF00, 32'h0000FFFF, 32'h0000FFFF, 32'h0000FFFF);
        do_start(700);
        run_query(NBEATS);
        n_vec++;
        if (pd_lane(0) !== PW'(707) || terminate[0] !== 1'b1 || first_term0 != 85 || done !== 1'b1) begin
            n_err++;
            $display("FAIL term_frozen pd0=%0d term0=%b first=%0d done=%b want 707/1/85/1",
                     pd_lane(0), terminate[0], first_term0, done);
        end
    endtask

    task automatic test_mixed;
        set_all(32'h12345678, 32'h12345678, 32'h12345679, 32'h00000000, 32'hFFFFFFFF);
        do_start(64'hFFFF);
        run_query(NBEATS);
        n_vec++;
        if (pd_lane(0) !== PW'(0) || pd_lane(1) !== PW'(3) || terminate !== 4'b1100 || done !== 1'b1 || beats_done != 96) begin
            n_err++;
            $display("FAIL mixed_final pd0=%0d pd1=%0d term=%b done=%b beats=%0d want 0/3/1100/1/96",
                     pd_lane(0), pd_lane(1), terminate, done, beats_done);
        end
    endtask

    task automatic test_seq_err;
        logic [LANES*PW-1:0] ones;
        for (int l = 0; l < LANES; l++) ones[l*PW +: PW] = PW'(1);
        do_start(64'hFFFF);
        in_valid = 1'b1;
        dim      = DW'(2);
        q_bit    = 1'b1;
        r_bits   = '0;
        @(negedge clk);
        in_valid = 1'b0;
        n_vec++;
        if (seq_err !== 1'b1 || partial_dist !== '0) begin
            n_err++;
            $display("FAIL seq_err_drop seq_err=%b pd=%h want 1/0", seq_err, partial_dist);
        end
        in_valid = 1'b1;
        dim      = '0;
        @(negedge clk);
        in_valid = 1'b0;
        n_vec++;
        if (seq_err !== 1'b1 || partial_dist !== ones) begin
            n_err++;
            $display("FAIL seq_err_resume seq_err=%b pd=%h want 1/%h", seq_err, partial_dist, ones);
        end
        do_start(64'hFFFF);
    endtask

    task automatic test_all_term;
        logic [LANES*PW-1:0] held;
        set_all(32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF);
        do_start(3 * (64'd1 << 32) - (64'd1 << 21) - (64'd1 << 19) + 3);
        run_query(NBEATS);
        n_vec++;
        if (beats_done != 41 || done !== 1'b1 || terminate !== 4'b1111) begin
            n_err++;
            $display("FAIL all_term beats=%0d done=%b term=%b want 41/1/1111", beats_done, done, terminate);
        end
        held     = partial_dist;
        in_valid = 1'b1;
        dim      = DW'(2);
        q_bit    = 1'b0;
        r_bits   = '1;
        @(negedge clk);
        in_valid = 1'b0;
        n_vec++;
        if (partial_dist !== held || in_ready !== 1'b0 || done !== 1'b1) begin
            n_err++;
            $display("FAIL done_hold pd=%h ready=%b done=%b want %h/0/1", partial_dist, in_ready, done, held);
        end
    endtask

    task automatic test_start_with_valid;
        set_all(32'h12345678, 32'h12345678, 32'h12345679, 32'h00000000, 32'hFFFFFFFF);
        do_start(64'hFFFF);
        in_valid = 1'b1;
        dim      = '0;
        q_bit    = 1'b1;
        r_bits   = '0;
        do_start(64'hFFFF);
        in_valid = 1'b0;
        run_query(NBEATS);
        n_vec++;
        if (pd_lane(1) !== PW'(3) || seq_err !== 1'b0 || beats_done != 96) begin
            n_err++;
            $display("FAIL start_valid pd1=%0d seq_err=%b beats=%0d want 3/0/96", pd_lane(1), seq_err, beats_done);
        end
    endtask

    task automatic test_reset_mid;
        set_all(32'h12345678, 32'h12345678, 32'h12345679, 32'h00000000, 32'hFFFFFFFF);
        do_start(64'hFFFF);
        run_query(51);
        #2;
        rst = 1'b0;
        #1;
        n_vec++;
        if (in_ready !== 1'b0 || done !== 1'b0 || seq_err !== 1'b0 || terminate !== '0 || partial_dist !== '0) begin
            n_err++;
            $display("FAIL reset_mid ready=%b done=%b seq_err=%b term=%b pd=%h want all 0",
                     in_ready, done, seq_err, terminate, partial_dist);
        end
        @(negedge clk);
        rst = 1'b1;
        do_start(64'hFFFF);
        run_query(NBEATS);
        n_vec++;
        if (pd_lane(0) !== PW'(0) || pd_lane(1) !== PW'(3) || terminate !== 4'b1100 || done !== 1'b1) begin
            n_err++;
            $display("FAIL reset_rerun pd0=%0d pd1=%0d term=%b done=%b want 0/3/1100/1",
                     pd_lane(0), pd_lane(1), terminate, done);
        end
    endtask

    initial begin
        test_reset();
        test_exact();
        test_terminate();
        test_mixed();
        test_seq_err();
        test_all_term();
        test_start_with_valid();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/multi_lane_bdu.md
MULTI_LANE_BDU -- requirements
Module: multi_lane_bdu

Interface
REQ-001 Parameter B, default 32, coordinate bit width.
REQ-002 Parameter D, default 3, dimension count (D>=1).
REQ-003 Parameter LANES, default 4, number of reference points evaluated in parallel against one query.
REQ-004 Derived constant PW = B+$clog2(D)+1 SHALL be the partial-distance width.
REQ-005 clk  in  1  single clock; all state on rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-low.
REQ-007 start  in  1  pulse: clear all lanes, capture threshold, begin a query.
REQ-008 threshold  in  PW  termination bound, sampled only on start.
REQ-009 in_valid  in  1  one bit-beat present this cycle.
REQ-010 in_ready  out  1  high only in ACTIVE.
REQ-011 dim  in  clog2(D)  dimension index of the beat.
REQ-012 q_bit  in  1  query bit, shared by all lanes.
REQ-013 r_bits  in  LANES  reference bit per lane.
REQ-014 terminate  out  LANES  per-lane sticky early-termination flag.
REQ-015 done  out  1  query finished (all beats consumed or all lanes terminated).
REQ-016 seq_err  out  1  sticky out-of-order beat flag.
REQ-017 partial_dist  out  LANES*PW  per-lane lower bound, lane 0 in LSBs.

Function
REQ-018 States IDLE, ACTIVE, DONE; start from any state SHALL go to ACTIVE next cycle with lanes, counters, seq_err cleared.
REQ-019 Beat order SHALL be MSB-first, bit-plane-major: for each bit position, dims 0..D-1; total D*B beats.
REQ-020 A beat is accepted when in_valid && in_ready; a beat whose dim differs from the expected dim SHALL be dropped and set seq_err.
REQ-021 Per lane, per dim: signed diff (B+1 bits) updates diff <= 2*diff + (q_bit - r_bit) on an accepted beat for that dim; k_d counts bits consumed.
REQ-022 Per-dim bound LB_d = 0 if diff==0, else ((|diff|-1) << (B-k_d)) + 1; at k_d=B this equals the exact |q-r|.
REQ-023 partial_dist per lane SHALL equal sum of LB_d (L1 lower bound), registered, visible the cycle after the accepted beat.
REQ-024 terminate[l] SHALL set the cycle after partial_dist[l] > threshold, and lane l state SHALL freeze from then.
REQ-025 ACTIVE -> DONE after the D*B-th accepted beat or when all lanes are terminated; done high in DONE only.
REQ-026 In DONE/IDLE, in_valid SHALL be ignored; outputs hold until start.
REQ-027 start coincident with in_valid: the beat SHALL be ignored.
REQ-028 partial_dist = threshold SHALL NOT terminate (strict greater-than).

Reset
REQ-029 On rst low: state IDLE, in_ready 0, terminate 0, done 0, seq_err 0, partial_dist 0, all diff/k_d/counters 0, threshold register 0, effective immediately regardless of clk; reset mid-query discards it.

Structure
REQ-030 Shared package SHALL hold the state enum and PW derivation function.
REQ-031 One sub-module, bdu_lane (per-lane diff registers, bound, compare, freeze), SHALL be instantiated LANES times under a common controller.

Verification
REQ-032 Default params, all dims q=0x0000FFFF, lane0 r=0x0000FF00, threshold 0xFFFF, 96 beats -> partial_dist[0]=765, terminate[0]=0, done the cycle after beat 95.
REQ-033 Same stimulus, threshold 700 -> partial_dist[0]=707 and terminate[0]=1 after beat 85 (0-based); lane0 frozen at 707 thereafter.
REQ-034 Lanes r=q, r=q^1, r=0, r=0xFFFFFFFF, threshold 0xFFFF -> final 0, 3, terminate, terminate; done when lanes 0/1 finish.
REQ-035 Beat with dim=2 when dim 0 expected -> seq_err=1, beat dropped, partial_dist unchanged.
REQ-036 All lanes exceed threshold at beat 40 -> done asserted next cycle, before 96 beats.
REQ-037 rst low mid-query at beat 50 -> all outputs 0 immediately; new start yields results identical to a fresh run.
